// File: rtl/crc16_tx_framer.sv
// Byte-to-serial transmit framer: serializes payload MSB-first while feeding the
// external serial CRC-16 stage, then appends the captured CRC MSB-first.
module crc16_tx_framer #(
  parameter int unsigned MAX_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        crc_sync,
  output logic        crc_data,
  input  logic [15:0] crc_in,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic [15:0] crc_out,
  output logic        err_underrun,
  output logic        err_len
);
  localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_CAPT, ST_CRC} state_t;

  state_t           r_state;
  logic [7:0]       r_shift;
  logic             r_last;
  logic [CNT_W-1:0] r_bcnt;
  logic [3:0]       r_bitcnt;
  logic [15:0]      r_crc_sh;
  logic             r_s_ready;
  logic             r_crc_sync;
  logic             r_crc_data;
  logic             r_tx_bit;
  logic             r_tx_valid;
  logic             r_tx_sof;
  logic             r_tx_eof;
  logic [15:0]      r_crc_out;
  logic             r_err_underrun;
  logic             r_err_len;

  logic             w_accept;
  logic [CNT_W-1:0] w_bcnt_inc;
  logic             w_hit_max;
  logic             w_first_max;

  assign w_accept    = s_valid & r_s_ready;
  assign w_bcnt_inc  = r_bcnt + CNT_W'(1);
  assign w_hit_max   = (w_bcnt_inc == CNT_W'(MAX_BYTES));
  assign w_first_max = (CNT_W'(1) == CNT_W'(MAX_BYTES));

  // Outputs are registered: each edge loads the values shown in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_shift        <= '0;
      r_last         <= 1'b0;
      r_bcnt         <= '0;
      r_bitcnt       <= '0;
      r_crc_sh       <= '0;
      r_s_ready      <= 1'b0;
      r_crc_sync     <= 1'b0;
      r_crc_data     <= 1'b0;
      r_tx_bit       <= 1'b0;
      r_tx_valid     <= 1'b0;
      r_tx_sof       <= 1'b0;
      r_tx_eof       <= 1'b0;
      r_crc_out      <= '0;
      r_err_underrun <= 1'b0;
      r_err_len      <= 1'b0;
    end else begin
      r_crc_sync     <= 1'b0;
      r_tx_sof       <= 1'b0;
      r_tx_eof       <= 1'b0;
      r_err_underrun <= 1'b0;
      r_err_len      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
            r_shift    <= s_data;
            r_last     <= s_last | w_first_max;
            r_err_len  <= ~s_last & w_first_max;
            r_bcnt     <= CNT_W'(1);
            r_s_ready  <= 1'b0;
            r_crc_sync <= 1'b1;
            r_state    <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          r_state    <= ST_DATA;
          r_bitcnt   <= '0;
          r_tx_valid <= 1'b1;
          r_tx_bit   <= r_shift[7];
          r_crc_data <= r_shift[7];
          r_tx_sof   <= 1'b1;
          r_shift    <= {r_shift[6:0], 1'b0};
        end
        ST_DATA: begin
          if (r_bitcnt != 4'd7) begin
            r_bitcnt   <= r_bitcnt + 4'd1;
            r_tx_bit   <= r_shift[7];
            r_crc_data <= r_shift[7];
            r_shift    <= {r_shift[6:0], 1'b0};
            r_s_ready  <= (r_bitcnt == 4'd6) & ~r_last;
          end else if (r_last) begin
            r_state    <= ST_CAPT;
            r_tx_valid <= 1'b0;
            r_tx_bit   <= 1'b0;
            r_crc_data <= 1'b0;
          end else if (w_accept) begin
            // Next byte arrives on the bit-0 cycle so the bit stream stays contiguous.
            r_bitcnt   <= '0;
            r_tx_bit   <= s_data[7];
            r_crc_data <= s_data[7];
            r_shift    <= {s_data[6:0], 1'b0};
            r_last     <= s_last | w_hit_max;
            r_err_len  <= ~s_last & w_hit_max;
            r_bcnt     <= w_bcnt_inc;
            r_s_ready  <= 1'b0;
          end else begin
            r_state        <= ST_IDLE;
            r_err_underrun <= 1'b1;
            r_s_ready      <= 1'b1;
            r_tx_valid     <= 1'b0;
            r_tx_bit       <= 1'b0;
            r_crc_data     <= 1'b0;
          end
        end
        ST_CAPT: begin
          r_crc_out  <= crc_in;
          r_crc_sh   <= {crc_in[14:0], 1'b0};
          r_tx_bit   <= crc_in[15];
          r_tx_valid <= 1'b1;
          r_bitcnt   <= '0;
          r_state    <= ST_CRC;
        end
        ST_CRC: begin
          if (r_bitcnt != 4'd15) begin
            r_bitcnt <= r_bitcnt + 4'd1;
            r_tx_bit <= r_crc_sh[15];
            r_crc_sh <= {r_crc_sh[14:0], 1'b0};
            r_tx_eof <= (r_bitcnt == 4'd14);
          end else begin
            r_state    <= ST_IDLE;
            r_tx_valid <= 1'b0;
            r_tx_bit   <= 1'b0;
            r_s_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready      = r_s_ready;
  assign crc_sync     = r_crc_sync;
  assign crc_data     = r_crc_data;
  assign tx_bit       = r_tx_bit;
  assign tx_valid     = r_tx_valid;
  assign tx_sof       = r_tx_sof;
  assign tx_eof       = r_tx_eof;
  assign crc_out      = r_crc_out;
  assign err_underrun = r_err_underrun;
  assign err_len      = r_err_len;
endmodule

// File: tb/tb_crc16_tx_framer.sv
// Bench for crc16_tx_framer: a bit-serial CRC stage model feeds crc_in, and frames
// are checked against a byte-wise CRC reference and an expected bit stream.
`timescale 1ns/1ps
module tb_crc16_tx_framer;
  logic        clk, rst, sel;
  logic [7:0]  s_data;
  logic        s_valid, s_last;

  logic        s_ready0, crc_sync0, crc_data0, tx_bit0, tx_valid0, tx_sof0, tx_eof0, err_underrun0, err_len0;
  logic        s_ready1, crc_sync1, crc_data1, tx_bit1, tx_valid1, tx_sof1, tx_eof1, err_underrun1, err_len1;
  logic [15:0] crc_in0, crc_out0, crc_in1, crc_out1;

  logic        s_ready_m, crc_sync_m, crc_data_m, tx_bit_m, tx_valid_m, tx_sof_m, tx_eof_m, err_underrun_m, err_len_m;
  logic [15:0] crc_out_m;

  int errors = 0;
  int checks = 0;

  crc16_tx_framer dut0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid & ~sel), .s_last(s_last),
    .s_ready(s_ready0), .crc_sync(crc_sync0), .crc_data(crc_data0), .crc_in(crc_in0),
    .tx_bit(tx_bit0), .tx_valid(tx_valid0), .tx_sof(tx_sof0), .tx_eof(tx_eof0),
    .crc_out(crc_out0), .err_underrun(err_underrun0), .err_len(err_len0)
  );

  crc16_tx_framer #(.MAX_BYTES(2)) dut1 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid & sel), .s_last(s_last),
    .s_ready(s_ready1), .crc_sync(crc_sync1), .crc_data(crc_data1), .crc_in(crc_in1),
    .tx_bit(tx_bit1), .tx_valid(tx_valid1), .tx_sof(tx_sof1), .tx_eof(tx_eof1),
    .crc_out(crc_out1), .err_underrun(err_underrun1), .err_len(err_len1)
  );

  assign s_ready_m      = sel ? s_ready1      : s_ready0;
  assign crc_sync_m     = sel ? crc_sync1     : crc_sync0;
  assign crc_data_m     = sel ? crc_data1     : crc_data0;
  assign tx_bit_m       = sel ? tx_bit1       : tx_bit0;
  assign tx_valid_m     = sel ? tx_valid1     : tx_valid0;
  assign tx_sof_m       = sel ? tx_sof1       : tx_sof0;
  assign tx_eof_m       = sel ? tx_eof1       : tx_eof0;
  assign err_underrun_m = sel ? err_underrun1 : err_underrun0;
  assign err_len_m      = sel ? err_len1      : err_len0;
  assign crc_out_m      = sel ? crc_out1      : crc_out0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial CRC-16 stage: clears on sync, otherwise absorbs one bit per clock.
  always @(posedge clk or posedge rst) begin
    if (rst) crc_in0 <= '0;
    else if (crc_sync0) crc_in0 <= '0;
    else crc_in0 <= {crc_in0[14:0], 1'b0} ^ ((crc_in0[15] ^ crc_data0) ? 16'h8005 : 16'h0000);
  end
  always @(posedge clk or posedge rst) begin
    if (rst) crc_in1 <= '0;
    else if (crc_sync1) crc_in1 <= '0;
    else crc_in1 <= {crc_in1[14:0], 1'b0} ^ ((crc_in1[15] ^ crc_data1) ? 16'h8005 : 16'h0000);
  end

  logic [7:0] pay[$];
  bit         use_last;
  bit         obs_bits[$];
  bit         obs_cd[$];
  int         gap_q[$];
  bit         exp_bits[$];
  bit         exp_cd[$];
  int         cyc, eof_cyc, und_cyc, len_cyc, sync_cyc, sof_cyc;
  int         sof_cnt, sync_cnt, und_cnt, len_cnt, eof_cnt, n_acc, wait_it;

  // Byte-wise CRC-16 (poly 0x8005, init 0, no reflection) of the first n payload bytes.
  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 0; i < n; i++) begin
      c = c ^ {pay[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    return c;
  endfunction

  // Expected tx bit stream and per-cycle crc_data (cycle 1 = SYNC) for n bytes.
  task automatic build_expect(input int n, input logic [15:0] c);
    exp_bits.delete();
    exp_cd.delete();
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) exp_bits.push_back(pay[i][b]);
    exp_cd.push_back(1'b0);
    foreach (exp_bits[k]) exp_cd.push_back(exp_bits[k]);
    for (int b = 15; b >= 0; b--) exp_bits.push_back(c[b]);
    for (int k = 0; k < 17; k++) exp_cd.push_back(1'b0);
  endtask

  // Offers pay[] to the selected DUT and records outputs per cycle after the first handshake.
  task automatic run_frame(input int stall_idx, input int stop_cyc);
    bit started;
    int iter;
    started = 0; iter = 0;
    obs_bits.delete(); obs_cd.delete(); gap_q.delete();
    cyc = 0; eof_cyc = -1; und_cyc = -1; len_cyc = -1; sync_cyc = -1; sof_cyc = -1;
    sof_cnt = 0; sync_cnt = 0; und_cnt = 0; len_cnt = 0; eof_cnt = 0; n_acc = 0; wait_it = 0;
    forever begin
      @(negedge clk);
      iter++;
      if (iter > 2000) break;
      if (started) begin
        cyc++;
        obs_cd.push_back(crc_data_m);
        if (tx_valid_m) obs_bits.push_back(tx_bit_m); else gap_q.push_back(cyc);
        if (crc_sync_m) begin sync_cnt++; sync_cyc = cyc; end
        if (tx_sof_m) begin sof_cnt++; sof_cyc = cyc; end
        if (err_len_m) begin len_cnt++; len_cyc = cyc; end
        if (err_underrun_m) begin und_cnt++; und_cyc = cyc; end
        if (tx_eof_m) begin eof_cnt++; eof_cyc = cyc; end
        if (tx_eof_m || err_underrun_m || cyc == stop_cyc) break;
      end
      if (n_acc < pay.size() && n_acc != stall_idx) begin
        s_valid = 1'b1;
        s_data  = pay[n_acc];
        s_last  = use_last && (n_acc == pay.size() - 1);
      end else begin
        s_valid = 1'b0;
      end
      if (s_valid && s_ready_m) begin
        if (!started) begin started = 1; wait_it = iter; end
        n_acc++;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready_m !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b exp 0", s_ready_m); end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({s_ready_m, crc_sync_m, crc_data_m, tx_bit_m, tx_valid_m, tx_sof_m, tx_eof_m,
           err_underrun_m, err_len_m, crc_out_m} !== {1'b1, 8'b0, 16'h0000}) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h exp %h", k, {s_ready_m, crc_sync_m, crc_data_m,
                 tx_bit_m, tx_valid_m, tx_sof_m, tx_eof_m, err_underrun_m, err_len_m, crc_out_m},
                 {1'b1, 8'b0, 16'h0000});
      end
    end
  endtask

  task automatic test_single_byte;
    logic [23:0] got;
    sel = 1'b0; use_last = 1'b1;
    pay.delete(); pay.push_back(8'h01);
    run_frame(-1, -1);
    got = '0;
    foreach (obs_bits[k]) if (k < 24) got[23-k] = obs_bits[k];
    checks++;
    if (obs_bits.size() != 24 || got !== 24'h018005) begin
      errors++; $display("FAIL single_bits: got %0d bits %h exp 24 bits 018005", obs_bits.size(), got);
    end
    checks++;
    if (crc_out_m !== 16'h8005) begin errors++; $display("FAIL single_crc: got %h exp 8005", crc_out_m); end
    checks++;
    if (eof_cyc != 26) begin errors++; $display("FAIL single_eof_cycle: got %0d exp 26", eof_cyc); end
    checks++;
    if (sync_cyc != 1 || sync_cnt != 1) begin
      errors++; $display("FAIL single_sync: got cycle %0d count %0d exp cycle 1 count 1", sync_cyc, sync_cnt);
    end
    checks++;
    if (sof_cyc != 2 || sof_cnt != 1) begin
      errors++; $display("FAIL single_sof: got cycle %0d count %0d exp cycle 2 count 1", sof_cyc, sof_cnt);
    end
  endtask

  task automatic test_check_string;
    string str;
    int mism;
    str = "123456789";
    sel = 1'b0; use_last = 1'b1;
    pay.delete();
    for (int k = 0; k < str.len(); k++) pay.push_back(8'(str[k]));
    run_frame(-1, -1);
    build_expect(9, 16'hFEE8);
    checks++;
    if (crc_out_m !== 16'hFEE8) begin errors++; $display("FAIL str_crc: got %h exp fee8", crc_out_m); end
    checks++;
    if (eof_cyc != 90) begin errors++; $display("FAIL str_eof_cycle: got %0d exp 90", eof_cyc); end
    checks++;
    if (sof_cnt != 1) begin errors++; $display("FAIL str_sof_count: got %0d exp 1", sof_cnt); end
    checks++;
    if (gap_q.size() != 2 || gap_q[0] != 1 || gap_q[1] != 74) begin
      errors++; $display("FAIL str_gaps: got %0d gaps, first %0d exp cycles 1 and 74", gap_q.size(),
                         gap_q.size() > 0 ? gap_q[0] : -1);
    end
    mism = 0;
    foreach (exp_bits[k]) if (k >= obs_bits.size() || obs_bits[k] !== exp_bits[k]) mism++;
    checks++;
    if (mism != 0 || obs_bits.size() != 88) begin
      errors++; $display("FAIL str_bits: got %0d bits with %0d wrong exp 88 bits", obs_bits.size(), mism);
    end
  endtask

  task automatic test_random;
    int n, mism;
    logic [15:0] c;
    sel = 1'b0; use_last = 1'b1;
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(1, 8));
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      c = ref_crc(n);
      build_expect(n, c);
      run_frame(-1, -1);
      checks++;
      if (wait_it != 1) begin errors++; $display("FAIL rnd_accept_wait f%0d: got %0d exp 1", f, wait_it); end
      checks++;
      if (crc_out_m !== c) begin errors++; $display("FAIL rnd_crc f%0d: got %h exp %h", f, crc_out_m, c); end
      checks++;
      if (eof_cyc != 8*n + 18 || eof_cnt != 1) begin
        errors++; $display("FAIL rnd_eof f%0d: got cycle %0d exp %0d", f, eof_cyc, 8*n + 18);
      end
      mism = 0;
      foreach (exp_bits[k]) if (k >= obs_bits.size() || obs_bits[k] !== exp_bits[k]) mism++;
      checks++;
      if (mism != 0 || obs_bits.size() != exp_bits.size()) begin
        errors++; $display("FAIL rnd_bits f%0d: got %0d bits with %0d wrong exp %0d", f, obs_bits.size(), mism, exp_bits.size());
      end
      mism = 0;
      foreach (exp_cd[k]) if (k >= obs_cd.size() || obs_cd[k] !== exp_cd[k]) mism++;
      checks++;
      if (mism != 0) begin errors++; $display("FAIL rnd_crc_data f%0d: got %0d wrong cycles exp 0", f, mism); end
      checks++;
      if (gap_q.size() != 2 || gap_q[0] != 1 || gap_q[1] != 8*n + 2) begin
        errors++; $display("FAIL rnd_gaps f%0d: got %0d gaps exp cycles 1 and %0d", f, gap_q.size(), 8*n + 2);
      end
      checks++;
      if (und_cnt != 0 || len_cnt != 0) begin
        errors++; $display("FAIL rnd_err_flags f%0d: got underrun %0d len %0d exp 0 0", f, und_cnt, len_cnt);
      end
    end
  endtask

  task automatic test_underrun;
    logic [15:0] prior;
    sel = 1'b0; use_last = 1'b1;
    prior = crc_out_m;
    pay.delete(); pay.push_back(8'($urandom)); pay.push_back(8'($urandom));
    run_frame(1, -1);
    checks++;
    if (und_cnt != 1 || und_cyc != 10) begin
      errors++; $display("FAIL und_pulse: got count %0d cycle %0d exp count 1 cycle 10", und_cnt, und_cyc);
    end
    checks++;
    if (eof_cnt != 0) begin errors++; $display("FAIL und_no_eof: got %0d eof exp 0", eof_cnt); end
    checks++;
    if (crc_out_m !== prior) begin errors++; $display("FAIL und_crc_held: got %h exp %h", crc_out_m, prior); end
    checks++;
    if (s_ready_m !== 1'b1 || tx_valid_m !== 1'b0) begin
      errors++; $display("FAIL und_idle: got ready %b valid %b exp 1 0", s_ready_m, tx_valid_m);
    end
    pay.delete(); pay.push_back(8'h00);
    run_frame(-1, -1);
    checks++;
    if (crc_out_m !== 16'h0000 || eof_cyc != 26) begin
      errors++; $display("FAIL und_recover: got crc %h eof %0d exp 0000 26", crc_out_m, eof_cyc);
    end
  endtask

  task automatic test_max_len;
    logic [15:0] c;
    int mism;
    sel = 1'b1; use_last = 1'b0;
    pay.delete(); pay.push_back(8'h31); pay.push_back(8'h32); pay.push_back(8'h33);
    c = ref_crc(2);
    build_expect(2, c);
    run_frame(-1, -1);
    checks++;
    if (len_cnt != 1 || len_cyc != 10) begin
      errors++; $display("FAIL len_pulse: got count %0d cycle %0d exp count 1 cycle 10", len_cnt, len_cyc);
    end
    checks++;
    if (n_acc != 2 || eof_cyc != 34) begin
      errors++; $display("FAIL len_frame: got %0d bytes eof %0d exp 2 bytes eof 34", n_acc, eof_cyc);
    end
    checks++;
    if (crc_out_m !== c) begin errors++; $display("FAIL len_crc: got %h exp %h", crc_out_m, c); end
    mism = 0;
    foreach (exp_bits[k]) if (k >= obs_bits.size() || obs_bits[k] !== exp_bits[k]) mism++;
    checks++;
    if (mism != 0 || obs_bits.size() != exp_bits.size()) begin
      errors++; $display("FAIL len_bits: got %0d bits with %0d wrong exp %0d", obs_bits.size(), mism, exp_bits.size());
    end
    use_last = 1'b1;
    pay.delete(); pay.push_back(8'h33);
    c = ref_crc(1);
    run_frame(-1, -1);
    checks++;
    if (wait_it != 1 || crc_out_m !== c || len_cnt != 0) begin
      errors++; $display("FAIL len_next_frame: got wait %0d crc %h err_len %0d exp 1 %h 0", wait_it, crc_out_m, len_cnt, c);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_midframe;
    sel = 1'b0; use_last = 1'b1;
    pay.delete(); pay.push_back(8'h01);
    run_frame(-1, 15);
    checks++;
    if (tx_valid_m !== 1'b1 || crc_out_m !== 16'h8005) begin
      errors++; $display("FAIL mid_in_crc: got valid %b crc %h exp 1 8005", tx_valid_m, crc_out_m);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s_ready_m, crc_sync_m, crc_data_m, tx_bit_m, tx_valid_m, tx_sof_m, tx_eof_m,
         err_underrun_m, err_len_m, crc_out_m} !== 25'h0) begin
      errors++;
      $display("FAIL mid_async_reset: got %h exp 0", {s_ready_m, crc_sync_m, crc_data_m, tx_bit_m,
               tx_valid_m, tx_sof_m, tx_eof_m, err_underrun_m, err_len_m, crc_out_m});
    end
    @(negedge clk);
    rst = 1'b0;
    run_frame(-1, -1);
    checks++;
    if (crc_out_m !== 16'h8005 || eof_cyc != 26) begin
      errors++; $display("FAIL mid_recover: got crc %h eof %0d exp 8005 26", crc_out_m, eof_cyc);
    end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_check_string;
    test_random;
    test_underrun;
    test_max_len;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crc16_tx_framer.md
# crc16_tx_framer

Byte-to-serial transmit framer that sits directly upstream of the serial CRC-16 stage. It accepts payload bytes over a valid/ready handshake and serializes them MSB-first onto a bit line. It drives the CRC stage's `sync` and `data_in` inputs and captures its `newcrc` result. It then appends the 16-bit CRC MSB-first, producing a complete framed bit stream for the line encoder.

## Interface
- `MAX_BYTES`, default 256: maximum payload bytes per frame (≥1); byte counter width is `$clog2(MAX_BYTES+1)`.
- `clk` input 1: clock.
- `rst` input 1: reset rst, asynchronous, active-high.
- `s_data` input 8: payload byte.
- `s_valid` input 1: `s_data` valid.
- `s_last` input 1: byte is the final payload byte of the frame.
- `s_ready` output 1: framer accepts a byte this cycle; transfer happens when `s_valid & s_ready`.
- `crc_sync` output 1: clear pulse to the CRC stage.
- `crc_data` output 1: serial payload bit to the CRC stage.
- `crc_in` input 16: `newcrc` from the CRC stage (combinational there).
- `tx_bit` output 1: framed serial bit.
- `tx_valid` output 1: `tx_bit` is meaningful.
- `tx_sof` output 1: first payload bit of the frame.
- `tx_eof` output 1: last CRC bit of the frame.
- `crc_out` output 16: CRC captured for the most recent frame, held until the next capture.
- `err_underrun` output 1: one-cycle pulse; next byte was not available when required.
- `err_len` output 1: one-cycle pulse; `MAX_BYTES` bytes were accepted without `s_last`.

## Operation
- CRC contract: poly 0x8005, init 0, MSB-first, no reflection, no final XOR.
  - The CRC stage clears on the edge where `crc_sync`=1.
  - The first data bit must be driven in the cycle immediately after the `crc_sync` cycle.
  - Bits must be contiguous; the CRC stage has no enable.
  - `crc_in` includes all N bits in the cycle after bit N is driven.
- FSM states: IDLE, SYNC, DATA, CAPT, CRC.
- IDLE:
  - `s_ready`=1.
  - On a handshake, load the shift register with `s_data`, latch `s_last`, set byte count to 1, and go to SYNC.
- SYNC (1 cycle): `crc_sync`=1, `tx_valid`=0. Go to DATA with bit count 0.
- DATA (8 cycles per byte):
  - `crc_data` = `tx_bit` = shift register bit 7, `tx_valid`=1.
  - Shift left each cycle.
  - `tx_sof`=1 only on bit 7 of the first byte.
- On bit count 7 (the byte's bit-0 cycle):
  - If the latched last flag is clear, `s_ready`=1.
  - Handshake: reload the byte, latch `s_last`, increment the byte count, and stay in DATA.
  - No `s_valid`: pulse `err_underrun` and go to IDLE. No CRC, no `tx_eof`; `crc_out` is unchanged.
  - Latched last set: go to CAPT.
  - Accepted byte count reaches `MAX_BYTES` with `s_last`=0: treat it as last and pulse `err_len` in the acceptance cycle. The frame completes normally.
- CAPT (1 cycle):
  - `tx_valid`=0, `crc_data`=0.
  - At the end of the cycle, latch `crc_in` into `crc_out` and into the CRC shift register.
- CRC (16 cycles):
  - `tx_bit` = CRC bit 15 down to bit 0, `tx_valid`=1.
  - `tx_eof`=1 on the 16th cycle; then go to IDLE.
- Outside DATA, `crc_data`=0 and `tx_bit`=0 whenever `tx_valid`=0.
- `s_ready` is 0 in SYNC, CAPT and CRC.

## Timing
- Reset (asynchronous, any state, including mid-frame):
  - State = IDLE.
  - `s_ready`=0 while `rst` is high; it rises in the first cycle after release.
  - All other outputs 0, including `crc_out`=0x0000 and both error flags.
- First byte accepted at edge E0:
  - `crc_sync` in cycle 1.
  - First payload bit in cycle 2.
- An N-byte frame occupies 8N+18 cycles from the first handshake to `tx_eof` inclusive: 1 SYNC, 8N DATA, 1 CAPT, 16 CRC.
- The next frame may be accepted in the cycle after `tx_eof`.
- Continuous bytes produce no bubble in DATA. The only `tx_valid` gaps are at SYNC and CAPT.
- An `err_underrun` pulse coincides with the first cycle back in IDLE.

## Test plan
- Reset release, `s_valid`=0: `s_ready`=1, all other outputs 0, `crc_out`=0x0000; the bench confirms this is stable for 20 cycles.
- Single byte 0x01, `s_last`=1:
  - `tx_bit` = 00000001 followed by 1000000000000101.
  - `crc_out`=0x8005.
  - `tx_eof` in the 26th cycle after the handshake.
- ASCII "123456789" back-to-back, `s_last` on '9':
  - `crc_out`=0xFEE8.
  - 72 contiguous payload bits, `tx_sof` exactly once, 90 cycles total.
- Underrun: 2-byte frame with `s_valid` low at byte 1's bit-0 cycle:
  - `err_underrun` pulse.
  - No `tx_eof`; `crc_out` retains its prior value.
  - A following 0x00 frame gives `crc_out`=0x0000.
- `MAX_BYTES`=2, three bytes 0x31 0x32 0x33 with no `s_last`:
  - `err_len` pulses on byte 2 acceptance.
  - Frame ends after 2 bytes with `crc_out` = CRC("12").
  - 0x33 is accepted as the start of the next frame.
- Assert `rst` during the CRC state: outputs go to 0 immediately; after release, a new 0x01 frame gives 0x8005.
